// File: rtl/gshare_ras_predictor_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the gshare + return-address-stack predictor.
//   ctr_t     : container type for a PHT saturating counter. It is sized for
//               the widest counter supported (CTR_MAX_BITS) so the helpers
//               work for any CTR_BITS the predictor is built with.
//   CTR_INIT  : reset value of a counter of a given width (weakly taken).
//   ctr_inc   : saturating increment, sticks at 2**bits-1.
//   ctr_dec   : saturating decrement, sticks at 0.
// No ports (package).
// ----------------------------------------------------------------------------
package bp_pkg;

    localparam int CTR_MAX_BITS = 8;

    typedef logic [CTR_MAX_BITS-1:0] ctr_t;

    // Largest value a counter of 'bits' width may hold.
    function automatic ctr_t ctr_max(input int unsigned bits);
        return (ctr_t'(1) << bits) - ctr_t'(1);
    endfunction

    // Weakly taken: only the MSB of the counter is set.
    function automatic ctr_t CTR_INIT(input int unsigned bits);
        return ctr_t'(1) << (bits - 1);
    endfunction

    function automatic ctr_t ctr_inc(input ctr_t v, input int unsigned bits);
        return (v >= ctr_max(bits)) ? v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

endpackage

// File: rtl/gshare_ras_predictor_if.sv
// ----------------------------------------------------------------------------
// gshare_ras_predictor_if
// Bundles the IF-stage prediction request/response and the EX-stage
// training/recovery signals of the branch predictor.
//   master : fetch/execute side (drives requests, receives predictions)
//   slave  : predictor side
// IF  : valid_in, ready_in, PC_IF, IM_IF, jump_*_IF, call_IF, ret_IF
//       -> jump_pred_IF, jump_addr_IF, ras_ptr_IF, ras_cnt_IF
// EX  : PC_EX, jump_ena_EX, jump_alw_EX, jump_taken_EX, flush_EX,
//       ras_ptr_EX, ras_cnt_EX
// ----------------------------------------------------------------------------
interface gshare_ras_predictor_if #(
    parameter int RAS_DEPTH = 4
);
    localparam int RAS_W = $clog2(RAS_DEPTH);

    logic             valid_in;
    logic             ready_in;
    logic [31:0]      PC_IF;
    logic [31:0]      IM_IF;
    logic             jump_ena_IF;
    logic             jump_alw_IF;
    logic             jump_ind_IF;
    logic             call_IF;
    logic             ret_IF;
    logic             jump_pred_IF;
    logic [31:0]      jump_addr_IF;
    logic [RAS_W-1:0] ras_ptr_IF;
    logic [RAS_W:0]   ras_cnt_IF;
    logic [31:0]      PC_EX;
    logic             jump_ena_EX;
    logic             jump_alw_EX;
    logic             jump_taken_EX;
    logic             flush_EX;
    logic [RAS_W-1:0] ras_ptr_EX;
    logic [RAS_W:0]   ras_cnt_EX;

    modport master (
        output valid_in, ready_in, PC_IF, IM_IF, jump_ena_IF, jump_alw_IF,
               jump_ind_IF, call_IF, ret_IF, PC_EX, jump_ena_EX, jump_alw_EX,
               jump_taken_EX, flush_EX, ras_ptr_EX, ras_cnt_EX,
        input  jump_pred_IF, jump_addr_IF, ras_ptr_IF, ras_cnt_IF
    );

    modport slave (
        input  valid_in, ready_in, PC_IF, IM_IF, jump_ena_IF, jump_alw_IF,
               jump_ind_IF, call_IF, ret_IF, PC_EX, jump_ena_EX, jump_alw_EX,
               jump_taken_EX, flush_EX, ras_ptr_EX, ras_cnt_EX,
        output jump_pred_IF, jump_addr_IF, ras_ptr_IF, ras_cnt_IF
    );

endinterface

// File: rtl/gshare_ras_predictor_ras.sv
// ----------------------------------------------------------------------------
// return_address_stack
// Circular return address stack with occupancy count and checkpoint restore.
//   clk, reset  : clock, asynchronous active-low reset
//   push        : store push_addr as the new top (call)
//   pop         : discard the top (return)
//   push & pop  : replace the top in place (or push if empty)
//   push_addr   : return address to store
//   flush       : restore ptr/cnt from ptr_in/cnt_in, overrides push/pop
//   top         : entry at the current pointer
//   ptr, cnt    : current top pointer and occupancy (checkpoint values)
// ----------------------------------------------------------------------------
module return_address_stack #(
    parameter int DEPTH = 4,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [31:0]  push_addr,
    input  logic         flush,
    input  logic [W-1:0] ptr_in,
    input  logic [W:0]   cnt_in,
    output logic [31:0]  top,
    output logic [W-1:0] ptr,
    output logic [W:0]   cnt
);

    localparam logic [W:0] CNT_FULL = (W+1)'(DEPTH);

    logic [31:0]  entries_q [DEPTH];
    logic [W-1:0] ptr_q, ptr_d;
    logic [W:0]   cnt_q, cnt_d;
    logic         wr_en;
    logic [W-1:0] wr_ptr;

    // Next pointer/count and the entry write. A flush comes from a
    // mispredicted older instruction, so the IF instruction is on the wrong
    // path and its push/pop is dropped entirely, including the entry write.
    // A full stack keeps advancing the pointer, overwriting the oldest entry.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = ptr_q;
        if (flush) begin
            ptr_d = ptr_in;
            cnt_d = cnt_in;
        end else if (push && pop) begin
            wr_en = 1'b1;
            if (cnt_q == '0) begin
                ptr_d  = ptr_q + 1'b1;
                wr_ptr = ptr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
            end
        end else if (push) begin
            ptr_d  = ptr_q + 1'b1;
            wr_ptr = ptr_q + 1'b1;
            wr_en  = 1'b1;
            cnt_d  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
        end else if (pop) begin
            if (cnt_q != '0) begin
                ptr_d = ptr_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Pointer, count and entry storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                entries_q[wr_ptr] <= push_addr;
            end
        end
    end

    assign top = entries_q[ptr_q];
    assign ptr = ptr_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/gshare_ras_predictor.sv
// ----------------------------------------------------------------------------
// gshare_ras_predictor
// gshare conditional-branch predictor plus return address stack. Predicts
// the IF instruction combinationally and trains from resolved EX branches.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : gshare_ras_predictor_if.slave (IF request/prediction and
//                EX training/flush signals)
// Parameters: PC_BITS (PHT index width), HIST_BITS (global history length),
// CTR_BITS (counter width), RAS_DEPTH (return stack entries).
// ----------------------------------------------------------------------------
module gshare_ras_predictor
    import bp_pkg::*;
#(
    parameter int PC_BITS   = 8,
    parameter int HIST_BITS = 8,
    parameter int CTR_BITS  = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    gshare_ras_predictor_if.slave       bus
);

    localparam int RAS_W       = $clog2(RAS_DEPTH);
    localparam int PHT_ENTRIES = 2 ** PC_BITS;

    typedef logic [PC_BITS-1:0]   idx_t;
    typedef logic [HIST_BITS-1:0] hist_t;
    typedef logic [CTR_BITS-1:0]  pctr_t;

    localparam pctr_t PHT_INIT = pctr_t'(CTR_INIT(CTR_BITS));

    pctr_t       pht_q [PHT_ENTRIES];
    pctr_t       pht_wr_d;
    hist_t       gbh_q, gbh_d;
    idx_t        r_idx, w_idx;
    ctr_t        pht_cur_w;
    ctr_t        pht_next_w;
    logic        train_en;
    logic        ras_act, ras_push, ras_pop;
    logic [31:0] ras_top;
    logic [RAS_W-1:0] ras_ptr;
    logic [RAS_W:0]   ras_cnt;
    logic [31:0] seq_target;
    logic        pred;
    logic [31:0] pred_addr;
    logic        unused_ok;

    // Index math: history is zero-extended to the PC index width and XORed.
    assign r_idx = bus.PC_IF[PC_BITS+1:2] ^ idx_t'(gbh_q);
    assign w_idx = bus.PC_EX[PC_BITS+1:2] ^ idx_t'(gbh_q);

    assign train_en   = bus.ready_in && bus.jump_ena_EX && !bus.jump_alw_EX;
    assign seq_target = bus.PC_IF + bus.IM_IF;

    // Counter update for the EX branch and the shifted global history.
    // Counters are widened into the package container type so the shared
    // saturation helpers can be used for any CTR_BITS.
    always_comb begin
        pht_cur_w  = ctr_t'(pht_q[w_idx]);
        pht_next_w = bus.jump_taken_EX ? ctr_inc(pht_cur_w, CTR_BITS)
                                       : ctr_dec(pht_cur_w);
        pht_wr_d   = pht_next_w[CTR_BITS-1:0];
        gbh_d      = gbh_q;
        if (train_en) begin
            gbh_d = hist_t'({gbh_q, bus.jump_taken_EX});
        end
    end

    // PHT and history registers. A same-cycle read of the entry being
    // written sees the old value because the write lands on the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gbh_q <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= PHT_INIT;
            end
        end else begin
            gbh_q <= gbh_d;
            if (train_en) begin
                pht_q[w_idx] <= pht_wr_d;
            end
        end
    end

    // RAS activity follows the IF instruction only when the pipeline moves.
    assign ras_act  = bus.valid_in && bus.ready_in && bus.jump_ena_IF;
    assign ras_push = ras_act && bus.call_IF;
    assign ras_pop  = ras_act && bus.ret_IF;

    return_address_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (RAS_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (bus.PC_IF + 32'd4),
        .flush     (bus.flush_EX),
        .ptr_in    (bus.ras_ptr_EX),
        .cnt_in    (bus.ras_cnt_EX),
        .top       (ras_top),
        .ptr       (ras_ptr),
        .cnt       (ras_cnt)
    );

    // Prediction mux. Direct jumps are always taken, returns use the RAS top
    // when it holds something, other indirects cannot be predicted, and
    // conditionals follow the counter MSB. The target is the PC-relative
    // one unless the RAS supplied it.
    always_comb begin
        pred      = 1'b0;
        pred_addr = seq_target;
        if (bus.valid_in && bus.jump_ena_IF) begin
            if (bus.jump_alw_IF && !bus.jump_ind_IF) begin
                pred = 1'b1;
            end else if (bus.jump_ind_IF) begin
                if (bus.ret_IF && (ras_cnt != '0)) begin
                    pred      = 1'b1;
                    pred_addr = ras_top;
                end
            end else begin
                pred = pht_q[r_idx][CTR_BITS-1];
            end
        end
    end

    assign bus.jump_pred_IF = pred;
    assign bus.jump_addr_IF = pred_addr;
    assign bus.ras_ptr_IF   = ras_ptr;
    assign bus.ras_cnt_IF   = ras_cnt;

    assign unused_ok = ^{bus.PC_IF, bus.PC_EX, pht_next_w};

endmodule

// File: tb/tb_gshare_ras_predictor.sv
// ----------------------------------------------------------------------------
// tb_gshare_ras_predictor
// Directed-vector bench for gshare_ras_predictor. The stimulus process drives
// one vector per cycle and queues its hand-computed expected outputs; a
// monitor compares the DUT outputs on the falling edge against the queue.
// ----------------------------------------------------------------------------
module tb_gshare_ras_predictor;

    logic clk;
    logic reset;
    logic chk_req;
    int   checks;
    int   failures;

    typedef struct {
        string       name;
        logic        pred;
        logic [31:0] addr;
        logic [1:0]  ptr;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb_q[$];

    gshare_ras_predictor_if #(.RAS_DEPTH(4)) bus_if();

    gshare_ras_predictor #(
        .PC_BITS   (8),
        .HIST_BITS (8),
        .CTR_BITS  (2),
        .RAS_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Compare one queued expectation against the live outputs.
    task automatic check_output(input exp_t e);
        checks++;
        if (bus_if.jump_pred_IF !== e.pred) begin
            failures++;
            $display("[TB] FAIL %s.pred actual=%0b required=%0b", e.name, bus_if.jump_pred_IF, e.pred);
        end
        checks++;
        if (bus_if.jump_addr_IF !== e.addr) begin
            failures++;
            $display("[TB] FAIL %s.addr actual=0x%08h required=0x%08h", e.name, bus_if.jump_addr_IF, e.addr);
        end
        checks++;
        if (bus_if.ras_ptr_IF !== e.ptr) begin
            failures++;
            $display("[TB] FAIL %s.ptr actual=%0d required=%0d", e.name, bus_if.ras_ptr_IF, e.ptr);
        end
        checks++;
        if (bus_if.ras_cnt_IF !== e.cnt) begin
            failures++;
            $display("[TB] FAIL %s.cnt actual=%0d required=%0d", e.name, bus_if.ras_cnt_IF, e.cnt);
        end
    endtask

    // Monitor: whenever a vector is presented, pop its expectation and compare.
    always @(negedge clk) begin
        if (chk_req) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                check_output(sb_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        bus_if.valid_in      = 1'b0;
        bus_if.ready_in      = 1'b1;
        bus_if.PC_IF         = '0;
        bus_if.IM_IF         = '0;
        bus_if.jump_ena_IF   = 1'b0;
        bus_if.jump_alw_IF   = 1'b0;
        bus_if.jump_ind_IF   = 1'b0;
        bus_if.call_IF       = 1'b0;
        bus_if.ret_IF        = 1'b0;
        bus_if.PC_EX         = '0;
        bus_if.jump_ena_EX   = 1'b0;
        bus_if.jump_alw_EX   = 1'b0;
        bus_if.jump_taken_EX = 1'b0;
        bus_if.flush_EX      = 1'b0;
        bus_if.ras_ptr_EX    = '0;
        bus_if.ras_cnt_EX    = '0;
    endtask

    // Advance to just after the next rising edge and clear the previous vector.
    task automatic step();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
        idle_inputs();
    endtask

    task automatic apply_stimulus(input logic alw, input logic ind, input logic call,
                                  input logic ret, input logic [31:0] pc, input logic [31:0] im);
        bus_if.valid_in    = 1'b1;
        bus_if.jump_ena_IF = 1'b1;
        bus_if.jump_alw_IF = alw;
        bus_if.jump_ind_IF = ind;
        bus_if.call_IF     = call;
        bus_if.ret_IF      = ret;
        bus_if.PC_IF       = pc;
        bus_if.IM_IF       = im;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic taken);
        bus_if.PC_EX         = pc;
        bus_if.jump_ena_EX   = 1'b1;
        bus_if.jump_alw_EX   = 1'b0;
        bus_if.jump_taken_EX = taken;
    endtask

    task automatic push_expect(input string name, input logic pred, input logic [31:0] addr,
                               input logic [1:0] ptr, input logic [2:0] cnt);
        exp_t e;
        e.name = name;
        e.pred = pred;
        e.addr = addr;
        e.ptr  = ptr;
        e.cnt  = cnt;
        sb_q.push_back(e);
        chk_req = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        chk_req  = 1'b0;
        reset    = 1'b0;
        idle_inputs();

        // Reset state
        step(); push_expect("reset_idle", 1'b0, 32'h0, 2'd0, 3'd0);

        // Conditional branch on a weakly-taken counter
        step(); reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 32'h100, 32'h20);
        push_expect("cond_weak_taken", 1'b1, 32'h120, 2'd0, 3'd0);

        // Three not-taken trainings of PC 0x100 (GBH stays 0, index 0x40)
        step(); apply_stimulus(0, 0, 0, 0, 32'h100, 32'h20); drive_ex(32'h100, 1'b0);
        push_expect("same_cycle_old_value", 1'b1, 32'h120, 2'd0, 3'd0);
        step(); apply_stimulus(0, 0, 0, 0, 32'h100, 32'h20); drive_ex(32'h100, 1'b0);
        push_expect("after_nt1", 1'b0, 32'h120, 2'd0, 3'd0);
        step(); apply_stimulus(0, 0, 0, 0, 32'h100, 32'h20); drive_ex(32'h100, 1'b0);
        push_expect("after_nt2", 1'b0, 32'h120, 2'd0, 3'd0);
        step(); apply_stimulus(0, 0, 0, 0, 32'h100, 32'h20);
        push_expect("sat_low_after_nt3", 1'b0, 32'h120, 2'd0, 3'd0);

        // Saturate entry 0x60 high while tracking the history shift
        step(); drive_ex(32'h180, 1'b1); push_expect("train_t1", 1'b0, 32'h0, 2'd0, 3'd0);
        step(); drive_ex(32'h184, 1'b1); push_expect("train_t2", 1'b0, 32'h0, 2'd0, 3'd0);
        step(); drive_ex(32'h18C, 1'b0); push_expect("train_nt", 1'b0, 32'h0, 2'd0, 3'd0);
        step(); apply_stimulus(0, 0, 0, 0, 32'h198, 32'h8);
        push_expect("sat_high", 1'b1, 32'h1A0, 2'd0, 3'd0);

        // Unconditional EX jump must not train
        step(); drive_ex(32'h198, 1'b0); bus_if.jump_alw_EX = 1'b1;
        push_expect("alw_ex", 1'b0, 32'h0, 2'd0, 3'd0);
        step(); apply_stimulus(0, 0, 0, 0, 32'h198, 32'h8);
        push_expect("alw_no_train", 1'b1, 32'h1A0, 2'd0, 3'd0);

        // ready_in low freezes training
        step(); drive_ex(32'h198, 1'b0); bus_if.ready_in = 1'b0;
        push_expect("stalled_ex", 1'b0, 32'h0, 2'd0, 3'd0);
        step(); apply_stimulus(0, 0, 0, 0, 32'h198, 32'h8);
        push_expect("stall_no_train", 1'b1, 32'h1A0, 2'd0, 3'd0);

        // Call then return, then return on an empty RAS
        step(); apply_stimulus(1, 0, 1, 0, 32'h200, 32'h40);
        push_expect("jal_call", 1'b1, 32'h240, 2'd0, 3'd0);
        step(); apply_stimulus(1, 1, 0, 1, 32'h300, 32'h0);
        push_expect("ret_hit", 1'b1, 32'h204, 2'd1, 3'd1);
        step(); apply_stimulus(1, 1, 0, 1, 32'h300, 32'h0);
        push_expect("ret_empty", 1'b0, 32'h300, 2'd0, 3'd0);

        // Stalled call leaves the RAS untouched
        step(); apply_stimulus(1, 0, 1, 0, 32'h400, 32'h10); bus_if.ready_in = 1'b0;
        push_expect("stalled_call", 1'b1, 32'h410, 2'd0, 3'd0);
        step(); push_expect("after_stall", 1'b0, 32'h0, 2'd0, 3'd0);

        // Five calls overflow a 4-deep RAS
        step(); apply_stimulus(1, 0, 1, 0, 32'h1000, 32'h40);
        push_expect("call1", 1'b1, 32'h1040, 2'd0, 3'd0);
        step(); apply_stimulus(1, 0, 1, 0, 32'h1100, 32'h40);
        push_expect("call2", 1'b1, 32'h1140, 2'd1, 3'd1);
        step(); apply_stimulus(1, 0, 1, 0, 32'h1200, 32'h40);
        push_expect("call3", 1'b1, 32'h1240, 2'd2, 3'd2);
        step(); apply_stimulus(1, 0, 1, 0, 32'h1300, 32'h40);
        push_expect("call4", 1'b1, 32'h1340, 2'd3, 3'd3);
        step(); apply_stimulus(1, 0, 1, 0, 32'h1400, 32'h40);
        push_expect("call5", 1'b1, 32'h1440, 2'd0, 3'd4);
        step(); apply_stimulus(1, 1, 0, 1, 32'h300, 32'h0);
        push_expect("ret1", 1'b1, 32'h1404, 2'd1, 3'd4);
        step(); apply_stimulus(1, 1, 0, 1, 32'h300, 32'h0);
        push_expect("ret2", 1'b1, 32'h1304, 2'd0, 3'd3);
        step(); apply_stimulus(1, 1, 0, 1, 32'h300, 32'h0);
        push_expect("ret3", 1'b1, 32'h1204, 2'd3, 3'd2);
        step(); apply_stimulus(1, 1, 0, 1, 32'h300, 32'h0);
        push_expect("ret4", 1'b1, 32'h1104, 2'd2, 3'd1);
        step(); apply_stimulus(1, 1, 0, 1, 32'h300, 32'h0);
        push_expect("ret5_empty", 1'b0, 32'h300, 2'd1, 3'd0);

        // Combined call+return: push when empty, replace top otherwise
        step(); apply_stimulus(1, 1, 1, 1, 32'h500, 32'h0);
        push_expect("coro_empty", 1'b0, 32'h500, 2'd1, 3'd0);
        step(); apply_stimulus(1, 1, 1, 1, 32'h600, 32'h0);
        push_expect("coro_replace", 1'b1, 32'h504, 2'd2, 3'd1);
        step(); apply_stimulus(1, 1, 0, 1, 32'h300, 32'h0);
        push_expect("ret_after_coro", 1'b1, 32'h604, 2'd2, 3'd1);

        // Flush restores the checkpoint and beats a same-cycle call
        step(); bus_if.flush_EX = 1'b1; bus_if.ras_ptr_EX = 2'd0; bus_if.ras_cnt_EX = 3'd0;
        push_expect("flush_restore", 1'b0, 32'h0, 2'd1, 3'd0);
        step(); apply_stimulus(1, 0, 1, 0, 32'h700, 32'h40);
        push_expect("call_ckpt", 1'b1, 32'h740, 2'd0, 3'd0);
        step(); apply_stimulus(1, 0, 1, 0, 32'h800, 32'h40);
        bus_if.flush_EX = 1'b1; bus_if.ras_ptr_EX = 2'd1; bus_if.ras_cnt_EX = 3'd1;
        push_expect("flush_vs_call", 1'b1, 32'h840, 2'd1, 3'd1);
        step(); apply_stimulus(1, 1, 0, 1, 32'h300, 32'h0);
        push_expect("flush_wins", 1'b1, 32'h704, 2'd1, 3'd1);

        // Asynchronous reset in the middle of training (GBH is 0x06 here)
        step(); apply_stimulus(1, 0, 1, 0, 32'h900, 32'h40);
        push_expect("pre_call", 1'b1, 32'h940, 2'd0, 3'd0);
        step(); apply_stimulus(0, 0, 0, 0, 32'h118, 32'h20); drive_ex(32'h118, 1'b0);
        push_expect("pre_reset", 1'b0, 32'h138, 2'd1, 3'd1);
        step(); reset = 1'b0; apply_stimulus(0, 0, 0, 0, 32'h100, 32'h20);
        push_expect("async_reset", 1'b1, 32'h120, 2'd0, 3'd0);
        step(); reset = 1'b1; apply_stimulus(0, 0, 0, 0, 32'h100, 32'h20);
        push_expect("post_reset", 1'b1, 32'h120, 2'd0, 3'd0);

        step();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
